stream_compute_ctrl: RTL
========================

// Module: stream_compute_ctrl
// PURPOSE
//  Sequencer for the tsim example accelerator datapath. Starts on launch from the host register file.
//  Streams `length` 64-bit elements from inp_baddr through a burst buffer and adds ADD_VALUE to each.
//  Writes the results to out_baddr, then pulses finish back to the register file (CSR finish bit).
// PARAMETERS
//  MEM_ADDR_BITS   64  byte address width of memory port and base addresses
//  MEM_DATA_BITS   64  element/beat width
//  MEM_LEN_BITS    8   width of mem_req_len (encodes beats-1)
//  HOST_DATA_BITS  32  width of length
//  BURST_LEN       8   max beats per burst; buffer depth; must be <= 2**MEM_LEN_BITS, power of 2
//  ADD_VALUE       1   constant added to every element
// PORTS
//  clock          in   1               single clock
//  reset          in   1               asynchronous, active-high
//  launch         in   1               CSR bit 0 (level); start on rising edge
//  finish         out  1               one-cycle pulse when job complete
//  length         in   HOST_DATA_BITS  element count
//  inp_baddr      in   MEM_ADDR_BITS   input byte base address
//  out_baddr      in   MEM_ADDR_BITS   output byte base address
//  mem_req_valid  out  1               burst request valid
//  mem_req_ready  in   1               burst request accepted
//  mem_req_opcode out  1               0 = read, 1 = write
//  mem_req_len    out  MEM_LEN_BITS    beats-1 of burst
//  mem_req_addr   out  MEM_ADDR_BITS   burst byte address
//  mem_rd_valid   in   1               read beat valid
//  mem_rd_ready   out  1               read beat accepted
//  mem_rd_bits    in   MEM_DATA_BITS   read beat data
//  mem_wr_valid   out  1               write beat valid
//  mem_wr_ready   in   1               write beat accepted
//  mem_wr_bits    out  MEM_DATA_BITS   write beat data
//  cycles         out  32              launch-to-finish cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state IDLE; buffer empty; all valids, finish, mem_req_*, cycles = 0; internal counters 0.
//  - Launch is registered; start = launch & ~launch_q in IDLE. Start events in any other state are ignored.
//  - On start: latch rem = length, raddr = inp_baddr, waddr = out_baddr. If length==0 -> DONE with no mem traffic.
//  - chunk = min(rem, BURST_LEN). Recompute it on each entry to RD_REQ.
//  - FSM states and transitions:
//    IDLE -> RD_REQ on start (length!=0).
//    RD_REQ: valid=1, opcode=0, addr=raddr, len=chunk-1; -> RD_DATA when valid&ready.
//    RD_DATA: mem_rd_ready=1 until chunk beats accepted. Each beat pushes mem_rd_bits+ADD_VALUE
//      into the buffer (mod 2**MEM_DATA_BITS). -> WR_REQ after the last beat.
//    WR_REQ: valid=1, opcode=1, addr=waddr, len=chunk-1; -> WR_DATA when valid&ready.
//    WR_DATA: mem_wr_valid = buffer non-empty, bits = buffer head; pop on valid&ready.
//      On the last beat: rem -= chunk, raddr/waddr += chunk*MEM_DATA_BITS/8. -> RD_REQ if rem!=0, else DONE.
//    DONE: finish=1 for exactly one cycle -> IDLE.
//  - mem_req_* fields stay stable while valid is high and ready is low. Valids never drop before their handshake.
//  - mem_rd_ready=0 outside RD_DATA; beats arriving then are not accepted. mem_wr_valid=0 outside WR_DATA.
//  - Address adds wrap mod 2**MEM_ADDR_BITS. No 4KB-boundary splitting.
//  - Latency: 0 cycles from valid&ready to next state. Minimum per burst = 2 + chunk + chunk cycles + stalls.
//  - Reset mid-job aborts immediately. finish is not pulsed; the next launch rising edge starts a fresh job.
// CONFIGURATION
//  - Macro STREAM_CTRL_CYCLE_COUNT_EN.
//    Defined: 32-bit counter clears on start, increments every non-IDLE cycle, saturates at 2**32-1,
//      and holds after finish until the next start. cycles = counter.
//    Undefined: no counter logic; cycles tied to 0.
// STRUCTURE
//  - Package stream_ctrl_pkg holds:
//    - state_t enum {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE}
//    - MEM_OP_RD=1'b0, MEM_OP_WR=1'b1
//    - ELEM_BYTES=MEM_DATA_BITS/8
//  - Sub-module stream_fifo: synchronous FIFO, WIDTH/DEPTH params, push/pop/full/empty, async reset.
//    Instantiated once with DEPTH=BURST_LEN.
// TESTING
//  - length=3, inp=0x1000, out=0x2000, data {5,6,7}.
//    -> one read (addr 0x1000, len 2), one write (addr 0x2000, len 2), bits {6,7,8}, one finish pulse.
//  - length=20, BURST_LEN=8.
//    -> bursts of 8,8,4: read addrs 0x1000,0x1040,0x1080; write addrs likewise from 0x2000; finish once.
//  - length=0 -> no mem_req_valid; finish pulses 2 cycles after launch edge; cycles=1 when macro defined.
//  - Random ready/valid stalls on all three channels, length=17.
//    -> req fields stable while stalled; output data = input+1 in order; no lost/duplicate beats.
//  - Data 0xFFFF_FFFF_FFFF_FFFF -> writes 0x0. Launch held high after finish -> no restart until low-then-high.
//  - Reset asserted in WR_DATA -> all outputs 0 same cycle. Relaunch with length=2 completes normally.

Source files
------------

// File: rtl/stream_ctrl_pkg.sv
// Shared state encoding, memory opcodes and element sizing for the stream compute sequencer.
package stream_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

  localparam int DEF_MEM_DATA_BITS = 64;
  localparam int ELEM_BYTES        = DEF_MEM_DATA_BITS / 8;

endpackage

// File: rtl/stream_fifo.sv
// Burst buffer: synchronous FIFO, DEPTH a power of 2 (>= 2); pop_dat shows the head, zero latency.
// Push is ignored when full and pop when empty, so the caller gates with full/empty.
module stream_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/stream_compute_ctrl.sv
// Read burst -> add ADD_VALUE -> write burst sequencer; handshakes move the FSM with 0-cycle latency, any low ready/valid stalls it.
// Defining STREAM_CTRL_CYCLE_COUNT_EN adds a saturating launch-to-finish counter on `cycles`; otherwise `cycles` is 0.
module stream_compute_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = DEF_MEM_DATA_BITS,
  parameter int MEM_LEN_BITS   = 8,
  parameter int HOST_DATA_BITS = 32,
  parameter int BURST_LEN      = 8,
  parameter int ADD_VALUE      = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  output logic                      finish,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [MEM_ADDR_BITS-1:0]  inp_baddr,
  input  logic [MEM_ADDR_BITS-1:0]  out_baddr,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  input  logic                      mem_rd_valid,
  output logic                      mem_rd_ready,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_wr_valid,
  input  logic                      mem_wr_ready,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  output logic [31:0]               cycles
);
  // One extra bit so a full burst of 2**MEM_LEN_BITS beats is representable.
  localparam int CW         = MEM_LEN_BITS + 1;
  localparam int BEAT_BYTES = MEM_DATA_BITS / 8;

  state_t                    state_q, state_d;
  logic                      launch_q, launch_d;
  logic [HOST_DATA_BITS-1:0] rem_q, rem_d;
  logic [MEM_ADDR_BITS-1:0]  raddr_q, raddr_d;
  logic [MEM_ADDR_BITS-1:0]  waddr_q, waddr_d;
  logic [CW-1:0]             chunk_q, chunk_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic                      start, rd_fire, wr_fire, last_beat;
  logic                      buf_full, buf_empty;
  logic [MEM_DATA_BITS-1:0]  buf_dat;
  logic [HOST_DATA_BITS-1:0] rem_next;
  logic [MEM_ADDR_BITS-1:0]  step;

  function automatic logic [CW-1:0] chunk_of(input logic [HOST_DATA_BITS-1:0] r);
    if (r < HOST_DATA_BITS'(BURST_LEN)) return CW'(r);
    return CW'(BURST_LEN);
  endfunction

  assign launch_d  = launch;
  assign start     = launch & ~launch_q & (state_q == IDLE);
  assign rd_fire   = mem_rd_valid & mem_rd_ready;
  assign wr_fire   = mem_wr_valid & mem_wr_ready;
  assign last_beat = (cnt_q == chunk_q - CW'(1));
  assign rem_next  = rem_q - HOST_DATA_BITS'(chunk_q);
  assign step      = MEM_ADDR_BITS'(chunk_q) * MEM_ADDR_BITS'(BEAT_BYTES);

  assign finish         = (state_q == DONE);
  assign mem_req_valid  = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_req_opcode = (state_q == WR_REQ) ? MEM_OP_WR : MEM_OP_RD;
  assign mem_req_len    = mem_req_valid ? MEM_LEN_BITS'(chunk_q - CW'(1)) : '0;
  assign mem_req_addr   = (state_q == RD_REQ) ? raddr_q :
                          (state_q == WR_REQ) ? waddr_q : '0;
  assign mem_rd_ready   = (state_q == RD_DATA) & ~buf_full;
  assign mem_wr_valid   = (state_q == WR_DATA) & ~buf_empty;
  assign mem_wr_bits    = mem_wr_valid ? buf_dat : '0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    chunk_d = chunk_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = length;
          raddr_d = inp_baddr;
          waddr_d = out_baddr;
          chunk_d = chunk_of(length);
          state_d = (length == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        cnt_d = '0;
        if (mem_req_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rd_fire) begin
          cnt_d = last_beat ? '0 : cnt_q + CW'(1);
          if (last_beat) state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_req_ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (wr_fire) begin
          cnt_d = last_beat ? '0 : cnt_q + CW'(1);
          if (last_beat) begin
            rem_d   = rem_next;
            raddr_d = raddr_q + step;
            waddr_d = waddr_q + step;
            chunk_d = chunk_of(rem_next);
            state_d = (rem_next == '0) ? DONE : RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      rem_q    <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      chunk_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      rem_q    <= rem_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      chunk_q  <= chunk_d;
      cnt_q    <= cnt_d;
    end
  end

  stream_fifo #(
    .WIDTH (MEM_DATA_BITS),
    .DEPTH (BURST_LEN)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (rd_fire),
    .push_dat (mem_rd_bits + MEM_DATA_BITS'(ADD_VALUE)),
    .pop      (wr_fire),
    .pop_dat  (buf_dat),
    .full     (buf_full),
    .empty    (buf_empty)
  );

`ifdef STREAM_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (start) cyc_d = '0;
    else if ((state_q != IDLE) && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycles = cyc_q;
`else
  assign cycles = '0;
`endif

endmodule
